// File: rtl/rst_ctrl.sv
// Board reset controller: power-on reset, debounced button, short press -> reset pulse, long press -> warm boot.
// Latency: press/release seen 2+DEB_CYCLES edges after the pad; reset pulse starts 1 edge after debounced release.
// Backpressure: none; free-running, every output registered (boot_sel is a constant).
module rst_ctrl #(
    parameter int unsigned POR_CYCLES  = 1024,
    parameter int unsigned DEB_CYCLES  = 12000,
    parameter int unsigned LONG_CYCLES = 24000000,
    parameter int unsigned RST_CYCLES  = 16,
    parameter logic [1:0]  BOOT_IMAGE  = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    output logic       pll_rst,
    output logic       boot_req,
    output logic [1:0] boot_sel,
    output logic       btn_pressed
);

    localparam int unsigned MAX_PL  = (POR_CYCLES > LONG_CYCLES) ? POR_CYCLES : LONG_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_PL > RST_CYCLES) ? MAX_PL : RST_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_ALL) + 1;
    localparam int unsigned DW      = $clog2(DEB_CYCLES) + 1;

    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    // Leaving PRESS at this count lands in ARMED exactly LONG_CYCLES edges after btn_pressed rose.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2) begin : g_chk_deb
        $error("rst_ctrl: DEB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= 1) begin : g_chk_long
        $error("rst_ctrl: LONG_CYCLES must be > 1");
    end
    if (RST_CYCLES < 1) begin : g_chk_rst
        $error("rst_ctrl: RST_CYCLES must be >= 1");
    end
    if (POR_CYCLES < 1) begin : g_chk_por
        $error("rst_ctrl: POR_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_POR, S_IDLE, S_PRESS, S_RST, S_ARMED, S_BOOT, S_WAIT_REL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    btn_sync;

    assign boot_sel = BOOT_IMAGE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync    <= 2'b00;
            deb_cnt     <= '0;
            btn_pressed <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], ~btn_n};
            if (btn_sync[1] == btn_pressed) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_pressed <= ~btn_pressed;
                deb_cnt     <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_POR;
            cnt      <= '0;
            pll_rst  <= 1'b1;
            boot_req <= 1'b0;
        end else begin
            case (state)
                S_POR: begin
                    if (cnt == POR_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                        state   <= btn_pressed ? S_WAIT_REL : S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (btn_pressed) begin
                        cnt   <= '0;
                        state <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    // Reaching the long-press length wins over a release on the same edge.
                    if (cnt == LONG_LAST) begin
                        cnt   <= '0;
                        state <= S_ARMED;
                    end else if (!btn_pressed) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        state   <= S_RST;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                        state   <= btn_pressed ? S_WAIT_REL : S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ARMED: begin
                    if (!btn_pressed) begin
                        cnt      <= '0;
                        pll_rst  <= 1'b1;
                        boot_req <= 1'b1;
                        state    <= S_BOOT;
                    end
                end
                S_BOOT: begin
                    pll_rst  <= 1'b1;
                    boot_req <= 1'b1;
                end
                S_WAIT_REL: begin
                    if (!btn_pressed) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt      <= '0;
                    pll_rst  <= 1'b1;
                    boot_req <= 1'b0;
                    state    <= S_POR;
                end
            endcase
        end
    end

endmodule
